// File: rtl/sprite_fetch_pkg.sv
// sprite_fetch_pkg: shared types and helpers for the sprite position fetcher.
//   - fetch_state_e : fetch FSM states
//   - field_idx_w() : width of the per-field index (X0,Y0,X1,Y1,...)
//   - default base address / field stride of the sprite table in memory
package sprite_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMMIT
    } fetch_state_e;

    localparam int DEFAULT_BASE_ADDR    = 6000;
    localparam int DEFAULT_FIELD_STRIDE = 4;

    // Two fields (X, Y) per sprite; n >= 1 so the result is always >= 1.
    function automatic int field_idx_w(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/sprite_pos_fetcher_if.sv
// sprite_pos_fetcher_if: read bus between the fetcher and memory port A.
//   mem_addr  : read address (fetcher -> memory)
//   mem_rd_en : high while a read is issued (fetcher -> memory)
//   mem_data  : read data, valid READ_LATENCY cycles after the address (memory -> fetcher)
// Modports: master = fetcher side, slave = memory side.
interface sprite_pos_fetcher_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [WIDTH-1:0]      mem_data;

    modport master (output mem_addr, output mem_rd_en, input mem_data);
    modport slave  (input mem_addr, input mem_rd_en, output mem_data);
endinterface

// File: rtl/sprite_pos_fetcher_tag_pipe.sv
// fetch_tag_pipe: DEPTH-stage shift register of {valid, field index} that
// tracks outstanding memory reads, so the returning data can be steered to
// the right shadow entry.
//   clk     : clock
//   clr_n   : synchronous active-low clear of every stage
//   in_vld  : a read is issued this cycle
//   in_idx  : field index of that read
//   out_vld : read data for out_idx is on the memory bus this cycle
//   out_idx : field index of the returning data
module fetch_tag_pipe
    import sprite_fetch_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx
);
    logic [DEPTH:1]            vld_pipe;
    logic [DEPTH:1][IDX_W-1:0] idx_pipe;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_vld;
            idx_pipe[1] <= in_idx;
            for (int i = 2; i <= DEPTH; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    assign out_vld = vld_pipe[DEPTH];
    assign out_idx = idx_pipe[DEPTH];
endmodule

// File: rtl/sprite_pos_fetcher.sv
// sprite_pos_fetcher: once per frame, reads X/Y for NUM_SPRITES objects from
// memory port A into a shadow bank and publishes them to the renderer in a
// single commit cycle, so pos_x/pos_y never show a partially updated frame.
//   clk         : clock
//   reset       : synchronous active-low reset
//   frame_start : one-cycle pulse at vblank start
//   mem         : read bus to memory port A (sprite_pos_fetcher_if.master)
//   pos_x/pos_y : packed coordinates, sprite i at [i*WIDTH +: WIDTH]
//   fetch_done  : pulse in the first cycle new positions are visible
//   busy        : fetch in progress (FETCH, DRAIN, COMMIT)
//   overrun     : sticky, frame_start arrived while busy
// Build option: define SPRITE_FETCH_CLAMP_EN to saturate X to H_RES-1 and
// Y to V_RES-1 (unsigned) at commit; otherwise raw values pass through.
module sprite_pos_fetcher
    import sprite_fetch_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int NUM_SPRITES  = 3,
    parameter int BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int FIELD_STRIDE = DEFAULT_FIELD_STRIDE,
    parameter int READ_LATENCY = 1,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    sprite_pos_fetcher_if.master         mem,
    output logic [NUM_SPRITES*WIDTH-1:0] pos_x,
    output logic [NUM_SPRITES*WIDTH-1:0] pos_y,
    output logic                         fetch_done,
    output logic                         busy,
    output logic                         overrun
);
    localparam int NF = 2 * NUM_SPRITES;
    localparam int IW = field_idx_w(NUM_SPRITES);
    localparam logic [IW-1:0]         LAST_IDX = IW'(NF - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(FIELD_STRIDE);

    if (READ_LATENCY < 1 || NUM_SPRITES < 1 || H_RES < 1 || V_RES < 1) begin : g_bad_cfg
        $error("sprite_pos_fetcher: READ_LATENCY, NUM_SPRITES, H_RES, V_RES must be >= 1");
    end

`ifdef SPRITE_FETCH_CLAMP_EN
    localparam logic [WIDTH-1:0] X_MAX = WIDTH'(H_RES - 1);
    localparam logic [WIDTH-1:0] Y_MAX = WIDTH'(V_RES - 1);

    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH-1:0] v,
                                             input logic [WIDTH-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction
`endif

    fetch_state_e                 state_q, state_d;
    logic [IW-1:0]                rd_idx;
    logic [ADDR_WIDTH-1:0]        rd_addr;
    logic                         rd_en;
    logic                         tag_vld;
    logic [IW-1:0]                tag_idx;
    logic [NF-1:0][WIDTH-1:0]     shadow;

    // Tags enter in the issue cycle and emerge exactly when the data arrives.
    fetch_tag_pipe #(
        .DEPTH (READ_LATENCY),
        .IDX_W (IW)
    ) u_tag_pipe (
        .clk     (clk),
        .clr_n   (reset),
        .in_vld  (rd_en),
        .in_idx  (rd_idx),
        .out_vld (tag_vld),
        .out_idx (tag_idx)
    );

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE:   if (frame_start) state_d = FETCH;
            FETCH: begin
                rd_en = 1'b1;
                if (rd_idx == LAST_IDX) state_d = DRAIN;
            end
            // The last field's tag leaving the pipe means the bank is complete.
            DRAIN:  if (tag_vld && tag_idx == LAST_IDX) state_d = COMMIT;
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign mem.mem_rd_en = rd_en;
    // Running address register: sits at BASE whenever no fetch is active.
    assign mem.mem_addr  = rd_addr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_idx     <= '0;
            rd_addr    <= BASE;
            shadow     <= '0;
            pos_x      <= '0;
            pos_y      <= '0;
            fetch_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            fetch_done <= (state_q == COMMIT);
            if (frame_start && busy) overrun <= 1'b1;

            if (state_q == FETCH) begin
                if (rd_idx == LAST_IDX) begin
                    rd_idx  <= '0;
                    rd_addr <= BASE;
                end else begin
                    rd_idx  <= rd_idx + IW'(1);
                    rd_addr <= rd_addr + STRIDE;
                end
            end

            if (tag_vld) shadow[tag_idx] <= mem.mem_data;

            if (state_q == COMMIT) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
`ifdef SPRITE_FETCH_CLAMP_EN
                    pos_x[i*WIDTH +: WIDTH] <= sat(shadow[2*i],   X_MAX);
                    pos_y[i*WIDTH +: WIDTH] <= sat(shadow[2*i+1], Y_MAX);
`else
                    pos_x[i*WIDTH +: WIDTH] <= shadow[2*i];
                    pos_y[i*WIDTH +: WIDTH] <= shadow[2*i+1];
`endif
                end
            end
        end
    end
endmodule

// File: doc/sprite_pos_fetcher.md
# sprite_pos_fetcher

Parametrised successor to the fixed six-address VGA position scan: once per frame it reads X/Y coordinates for `NUM_SPRITES` objects from the shared memory's VGA read port and presents them as stable, tear-free registers to the VGA renderer. Reads are issued at one address per cycle from a configurable base and stride, and tolerate a configurable memory read latency. Fetched values go into a shadow bank, and the visible outputs update atomically in a single commit cycle. It sits between `mem` port A and `vga`.

## Interface
- `WIDTH`, 16, coordinate/data width
- `ADDR_WIDTH`, 16, memory address width
- `NUM_SPRITES`, 3, number of objects; each has an X and a Y field
- `BASE_ADDR`, 6000, address of sprite 0 X
- `FIELD_STRIDE`, 4, address step between consecutive fields
- `READ_LATENCY`, 1, cycles from `mem_addr` valid to `mem_data` valid (≥1)
- `H_RES`, 640 and `V_RES`, 480, screen size used only by the clamp option

Ports:
- `clk`  in  1  system clock, single clock domain
- `reset`  in  1  synchronous, active-low reset
- `frame_start`  in  1  one-cycle pulse from `vga` at vblank start
- `mem_addr`  out  ADDR_WIDTH  read address to memory port A
- `mem_rd_en`  out  1  high while a read is being issued
- `mem_data`  in  WIDTH  read data from port A
- `pos_x`  out  NUM_SPRITES*WIDTH  packed X; sprite i is in bits [i*WIDTH +: WIDTH]
- `pos_y`  out  NUM_SPRITES*WIDTH  packed Y, same packing as `pos_x`
- `fetch_done`  out  1  one-cycle pulse in the first cycle new positions are visible
- `busy`  out  1  high in FETCH, DRAIN and COMMIT
- `overrun`  out  1  sticky; set when `frame_start` arrives while `busy`

## Operation
- States:
  - IDLE → FETCH when `frame_start` is sampled high.
  - FETCH issues 2·NUM_SPRITES reads, then → DRAIN.
  - DRAIN waits for the last read data, then → COMMIT.
  - COMMIT copies shadow to outputs, then → IDLE.
- Read order is X0, Y0, X1, Y1, …. Field k is read from `BASE_ADDR + k*FIELD_STRIDE`, k = 0..2N−1. Address arithmetic is modulo 2^ADDR_WIDTH.
- A tag pipeline of depth READ_LATENCY carries (valid, k). When the tag emerges, `mem_data` is written to the shadow entry for field k.
- In IDLE: `mem_addr` = `BASE_ADDR`, `mem_rd_en` = 0.
- COMMIT copies the whole shadow bank to `pos_x`/`pos_y` on one edge. Outputs never show a partial frame.
- `frame_start` while `busy`: ignored and `overrun` set. Only reset clears `overrun`.
- Reset (any state, including mid-fetch):
  - state IDLE, tag pipe cleared, shadow cleared.
  - `pos_x`, `pos_y` = 0.
  - `fetch_done`, `busy`, `overrun`, `mem_rd_en` = 0.
  - `mem_addr` = `BASE_ADDR`.
  - No commit of partial data.

## Timing
- `frame_start` is high in cycle 0.
- Reads issue in cycles 1..2N, with `mem_rd_en` = 1 in exactly those cycles.
- Field k data is sampled at the end of cycle 1+k+READ_LATENCY.
- COMMIT is cycle 2N+READ_LATENCY+1.
- New outputs and `fetch_done` appear in cycle 2N+READ_LATENCY+2. For N=3, L=1 that is cycle 9.
- `busy` is high in cycles 1..2N+READ_LATENCY+1.
- A `frame_start` in the same cycle `fetch_done` is high is accepted, because the state is IDLE.
- Minimum accepted `frame_start` spacing is 2N+READ_LATENCY+2 cycles.

## Configuration
- `SPRITE_FETCH_CLAMP_EN` defined:
  - at commit, X is saturated to H_RES−1 and Y to V_RES−1;
  - values are treated as unsigned.
- Undefined: raw memory values pass through unchanged.

## Structure
- Package `sprite_fetch_pkg` holds:
  - the state enum (IDLE, FETCH, DRAIN, COMMIT);
  - the field-index width function, $clog2(2·NUM_SPRITES);
  - default base/stride constants.
- One sub-module, `fetch_tag_pipe`: a READ_LATENCY-deep shift register of {valid, field index} with synchronous active-low clear.

## Test plan
- Reset-during-run check:
  - Memory holds 6000=100, 6004=200, 6008=300, 6012=50, 6016=320, 6020=240. Pulse `frame_start` with defaults.
  - Required: addresses 6000..6020 step 4 in cycles 1..6; in cycle 9, `pos_x`={320,300,100}, `pos_y`={240,50,200} (packed sprite2..sprite0) and `fetch_done`=1.
  - Then: reset low in cycle 4 of a second fetch gives all outputs 0 the next cycle; `mem_rd_en`=0.
- Atomic commit: change memory between frames; `pos_x`/`pos_y` hold the old values until the single `fetch_done` cycle, then switch together.
- Overrun: second `frame_start` in cycle 3 is ignored and `overrun`=1, still 1 after a later clean frame.
- Back-to-back: `frame_start` in the `fetch_done` cycle starts a new fetch the next cycle, with no overrun.
- `READ_LATENCY`=3, `NUM_SPRITES`=4, `FIELD_STRIDE`=2, `BASE_ADDR`=0xFFFC:
  - addresses wrap FFFC, FFFE, 0000, …;
  - outputs appear in cycle 13.
- With `SPRITE_FETCH_CLAMP_EN`:
  - X=1000 yields 639;
  - Y=480 yields 479;
  - Y=479 stays 479.
